mem_arbiter: RTL and testbench

- Sequences the single shared simulated memory port between the instruction-fetch requester and the data-memory (MEM stage) requester.
- Grants one outstanding transaction at a time. Data has priority; a starvation guard bounds how long fetch can be locked out.
- Raises per-stage stall signals consumed by the hazard detection unit (PC/IFID enable, EXMEM/MEMWB enable).
- Sits between the IF/MEM stages and `simulated_mem`; enforces a response timeout so the core never hangs.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/arb_timeout_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: command encodings, FSM states
// and the registered command bundle driven toward simulated_mem.
package mem_arbiter_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  // Returned to fetch when memory never answers, so the core executes a NOP.
  localparam logic [31:0] FETCH_TIMEOUT_DATA = 32'h0000_0013;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE_I = 3'd1,
    ARB_ISSUE_D = 3'd2,
    ARB_BUSY_I  = 3'd3,
    ARB_BUSY_D  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_cmd_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Response-timeout counter: counts enabled cycles since the last clear and flags
// when TIMEOUT-1 has been reached. Reusable by later cache controllers.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single simulated memory port between instruction fetch and the
// MEM stage: data first, bounded fetch starvation, one outstanding transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req_val,
  input  logic [31:0] imem_req_addr,
  output logic        imem_req_rdy,
  output logic        imem_resp_val,
  output logic [31:0] imem_resp_data,
  input  logic        dmem_req_val,
  input  logic        dmem_req_write,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_wdata,
  input  logic [3:0]  dmem_req_mask,
  output logic        dmem_req_rdy,
  output logic        dmem_resp_val,
  output logic [31:0] dmem_resp_data,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err_timeout
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;

  logic in_idle, busy, finishing, timer_expired, starve_block;

  assign in_idle   = !rst && (state_q == ARB_IDLE);
  assign busy      = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  assign finishing = mem_valid || timer_expired;

  // Fetch wins only once data has taken STARVE_LIMIT grants back to back.
  assign starve_block = imem_req_val && (starve_q == SW'(STARVE_LIMIT));
  assign dmem_req_rdy = in_idle && dmem_req_val && !starve_block;
  assign imem_req_rdy = in_idle && imem_req_val && !dmem_req_rdy;

  assign stall_if  = !rst && imem_req_val && !imem_resp_val;
  assign stall_mem = !rst && dmem_req_val && !dmem_resp_val;

  assign mem_cmd        = cmd_q.cmd;
  assign mem_addr       = cmd_q.addr;
  assign mem_write_data = cmd_q.wdata;
  assign mem_mask       = cmd_q.mask;
  assign err_timeout    = err_q;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!busy),
    .enable_i  (busy),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      cmd_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    starve_d = starve_q;
    err_d    = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (dmem_req_rdy) begin
          state_d     = ARB_ISSUE_D;
          cmd_d.cmd   = dmem_req_write;
          cmd_d.addr  = dmem_req_addr;
          cmd_d.wdata = dmem_req_wdata;
          cmd_d.mask  = dmem_req_mask;
          if (!imem_req_val) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (imem_req_rdy) begin
          state_d     = ARB_ISSUE_I;
          cmd_d.cmd   = MEM_CMD_READ;
          cmd_d.addr  = imem_req_addr;
          cmd_d.wdata = '0;
          cmd_d.mask  = '0;
          starve_d    = '0;
        end
      end
      ARB_ISSUE_I: state_d = ARB_BUSY_I;
      ARB_ISSUE_D: state_d = ARB_BUSY_D;
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (finishing) begin
          state_d = ARB_IDLE;
          if (!mem_valid) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_enable     = 1'b0;
    imem_resp_val  = 1'b0;
    dmem_resp_val  = 1'b0;
    imem_resp_data = mem_valid ? mem_load_data : FETCH_TIMEOUT_DATA;
    dmem_resp_data = mem_valid ? mem_load_data : '0;
    if (!rst) begin
      unique case (state_q)
        ARB_ISSUE_I, ARB_ISSUE_D: mem_enable    = 1'b1;
        ARB_BUSY_I:               imem_resp_val = finishing;
        ARB_BUSY_D:               dmem_resp_val = finishing;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: accept table, directed multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TB_STARVE  = 4;
  localparam int unsigned TB_TIMEOUT = 8;

  logic        clk, rst;
  logic        imem_req_val;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy, imem_resp_val;
  logic [31:0] imem_resp_data;
  logic        dmem_req_val, dmem_req_write;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_mask;
  logic        dmem_req_rdy, dmem_resp_val;
  logic [31:0] dmem_resp_data;
  logic        mem_enable, mem_cmd;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_mask;
  logic [31:0] mem_load_data;
  logic        mem_valid;
  logic        stall_if, stall_mem, err_timeout;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_arbiter #(
    .STARVE_LIMIT (TB_STARVE),
    .TIMEOUT      (TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_val   (imem_req_val),
    .imem_req_addr  (imem_req_addr),
    .imem_req_rdy   (imem_req_rdy),
    .imem_resp_val  (imem_resp_val),
    .imem_resp_data (imem_resp_data),
    .dmem_req_val   (dmem_req_val),
    .dmem_req_write (dmem_req_write),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_mask  (dmem_req_mask),
    .dmem_req_rdy   (dmem_req_rdy),
    .dmem_resp_val  (dmem_resp_val),
    .dmem_resp_data (dmem_resp_data),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_mask       (mem_mask),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid),
    .stall_if       (stall_if),
    .stall_mem      (stall_mem),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    imem_req_val   = 1'b0; imem_req_addr  = '0;
    dmem_req_val   = 1'b0; dmem_req_write = 1'b0;
    dmem_req_addr  = '0;   dmem_req_wdata = '0; dmem_req_mask = '0;
    mem_valid      = 1'b0; mem_load_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ival, dval, dwr;
    logic        irdy, drdy, sif, smem;
    logic [31:0] addr;
    logic        cmd;
  } vec_t;

  // Grants observed in one starvation run; 1 = data, 0 = fetch, oldest in MSBs.
  task automatic starve_run(output int unsigned n, output logic [15:0] pat);
    int unsigned left;
    logic        dseen, iseen;
    left = 5; n = 0; pat = '0;
    imem_req_val = 1'b1; imem_req_addr = 32'h300;
    dmem_req_val = 1'b1; dmem_req_write = 1'b1;
    dmem_req_addr = 32'h40; dmem_req_wdata = 32'hA5A5_0000; dmem_req_mask = 4'hF;
    mem_valid = 1'b1; mem_load_data = 32'h1111_2222;
    for (int cyc = 0; cyc < 80 && (left > 0 || imem_req_val); cyc++) begin
      settle();
      if (dmem_req_rdy) begin pat = {pat[14:0], 1'b1}; n++; end
      if (imem_req_rdy) begin pat = {pat[14:0], 1'b0}; n++; end
      dseen = dmem_resp_val;
      iseen = imem_resp_val;
      tick();
      if (dseen) begin
        left--;
        if (left == 0) dmem_req_val = 1'b0;
        dmem_req_addr  = dmem_req_addr + 32'd4;
        dmem_req_wdata = dmem_req_wdata + 32'd1;
      end
      if (iseen) imem_req_val = 1'b0;
    end
    chk("starve_drained", left + 32'(imem_req_val), 0);
    mem_valid = 1'b0;
    clear_inputs();
  endtask

  vec_t vecs[6];

  // Randomized-test model state
  int unsigned owner, age, starve;
  logic        merr, i_act, d_act, d_wr, mv;
  logic [31:0] i_addr, d_addr, d_wdata, ld;
  logic [3:0]  d_mask;
  logic        t_cmd;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_mask;
  logic        e_drdy, e_irdy, e_en, done, e_iresp, e_dresp;
  int unsigned sn;
  logic [15:0] spat;

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();

    // ---- Accept table: reset state, then first-cycle arbitration after reset
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200,  1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1};
    for (int v = 0; v < 6; v++) begin
      clear_inputs();
      imem_req_val = vecs[v].ival; imem_req_addr = 32'h200;
      dmem_req_val = vecs[v].dval; dmem_req_write = vecs[v].dwr;
      dmem_req_addr = 32'h1000; dmem_req_wdata = 32'h1234_5678; dmem_req_mask = 4'hF;
      rst = 1'b1;
      settle();
      chk("rst_irdy", imem_req_rdy, 0);
      chk("rst_drdy", dmem_req_rdy, 0);
      chk("rst_stall_if", stall_if, 0);
      chk("rst_stall_mem", stall_mem, 0);
      chk("rst_enable", mem_enable, 0);
      tick();
      rst = 1'b0;
      settle();
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_cmd", mem_cmd, 0);
      chk("rst_mem_mask", mem_mask, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
      chk("rst_err", err_timeout, 0);
      chk("tbl_irdy", imem_req_rdy, vecs[v].irdy);
      chk("tbl_drdy", dmem_req_rdy, vecs[v].drdy);
      chk("tbl_stall_if", stall_if, vecs[v].sif);
      chk("tbl_stall_mem", stall_mem, vecs[v].smem);
      tick();
      settle();
      chk("tbl_enable", mem_enable, vecs[v].ival | vecs[v].dval);
      chk("tbl_addr", mem_addr, vecs[v].addr);
      chk("tbl_cmd", mem_cmd, vecs[v].cmd);
    end

    // ---- Fetch only, memory latency 3
    clear_inputs(); do_reset();
    imem_req_val = 1'b1; imem_req_addr = 32'h100;
    settle();
    chk("fo_irdy_c0", imem_req_rdy, 1);
    chk("fo_stall_c0", stall_if, 1);
    tick(); settle();
    chk("fo_en_c1", mem_enable, 1);
    chk("fo_addr_c1", mem_addr, 32'h100);
    chk("fo_cmd_c1", mem_cmd, 0);
    chk("fo_stall_c1", stall_if, 1);
    tick(); settle();
    chk("fo_en_c2", mem_enable, 0);
    chk("fo_resp_c2", imem_resp_val, 0);
    chk("fo_stall_c2", stall_if, 1);
    tick(); settle();
    chk("fo_stall_c3", stall_if, 1);
    tick();
    mem_valid = 1'b1; mem_load_data = 32'h0050_0093;
    settle();
    chk("fo_resp_c4", imem_resp_val, 1);
    chk("fo_data_c4", imem_resp_data, 32'h0050_0093);
    chk("fo_stall_c4", stall_if, 0);
    tick();
    mem_valid = 1'b0; imem_req_val = 1'b0;
    settle();
    chk("fo_resp_c5", imem_resp_val, 0);

    // ---- Store: exact command fields on the enable cycle
    clear_inputs(); do_reset();
    dmem_req_val = 1'b1; dmem_req_write = 1'b1; dmem_req_addr = 32'h20;
    dmem_req_wdata = 32'hDEAD_BEEF; dmem_req_mask = 4'b0011;
    settle();
    chk("st_drdy", dmem_req_rdy, 1);
    tick(); settle();
    chk("st_en", mem_enable, 1);
    chk("st_cmd", mem_cmd, 1);
    chk("st_addr", mem_addr, 32'h20);
    chk("st_wdata", mem_write_data, 32'hDEAD_BEEF);
    chk("st_mask", mem_mask, 4'b0011);
    tick();
    mem_valid = 1'b1;
    settle();
    chk("st_resp", dmem_resp_val, 1);
    chk("st_stall_mem", stall_mem, 0);
    tick();
    clear_inputs();

    // ---- Timeout: memory silent, NOP after 8 BUSY cycles, sticky error
    clear_inputs(); do_reset();
    imem_req_val = 1'b1; imem_req_addr = 32'h400;
    tick(); tick();
    for (int c = 2; c <= 9; c++) begin
      settle();
      chk("to_resp", imem_resp_val, (c == 9) ? 1 : 0);
      if (c == 9) chk("to_data", imem_resp_data, 32'h0000_0013);
      chk("to_err_pre", err_timeout, 0);
      tick();
    end
    imem_req_val = 1'b0;
    settle();
    chk("to_err_set", err_timeout, 1);
    for (int c = 0; c < 5; c++) tick();
    chk("to_err_sticky", err_timeout, 1);
    do_reset();
    settle();
    chk("to_err_cleared", err_timeout, 0);

    // ---- Reset while BUSY_D, late mem_valid must be ignored
    clear_inputs(); do_reset();
    dmem_req_val = 1'b1; dmem_req_addr = 32'h2000; dmem_req_mask = 4'h5;
    settle();
    chk("rm_drdy", dmem_req_rdy, 1);
    tick(); tick();
    rst = 1'b1;
    settle();
    chk("rm_resp_in_rst", dmem_resp_val, 0);
    chk("rm_stall_in_rst", stall_mem, 0);
    tick();
    rst = 1'b0; dmem_req_val = 1'b0;
    mem_valid = 1'b1; mem_load_data = 32'hCAFE_F00D;
    settle();
    chk("rm_no_resp", dmem_resp_val, 0);
    chk("rm_enable", mem_enable, 0);
    chk("rm_addr", mem_addr, 0);
    chk("rm_mask", mem_mask, 0);
    chk("rm_cmd", mem_cmd, 0);
    chk("rm_err", err_timeout, 0);
    tick();
    mem_valid = 1'b0; imem_req_val = 1'b1; imem_req_addr = 32'h500;
    settle();
    chk("rm_idle_accept", imem_req_rdy, 1);
    clear_inputs(); do_reset();

    // ---- Starvation: 4 data grants, then fetch, then data; twice in a row
    for (int r = 0; r < 2; r++) begin
      starve_run(sn, spat);
      chk("starve_count", sn, 6);
      chk("starve_order", 32'(spat), 32'b111101);
    end

    // ---- Randomized traffic against a transaction-level model
    clear_inputs(); do_reset();
    owner = 0; age = 0; starve = 0; merr = 1'b0; i_act = 1'b0; d_act = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_mask = '0; d_wr = 1'b0;
    t_cmd = 1'b0; t_addr = '0; t_wdata = '0; t_mask = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1'b1; d_wr = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_wdata = $urandom; d_mask = 4'($urandom_range(0, 15));
      end
      mv = (owner != 0 && age >= 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      ld = $urandom;
      imem_req_val = i_act; imem_req_addr = i_addr;
      dmem_req_val = d_act; dmem_req_write = d_wr; dmem_req_addr = d_addr;
      dmem_req_wdata = d_wdata; dmem_req_mask = d_mask;
      mem_valid = mv; mem_load_data = ld;
      settle();

      e_drdy  = (owner == 0) && d_act && !(i_act && starve == TB_STARVE);
      e_irdy  = (owner == 0) && i_act && !e_drdy;
      e_en    = (owner != 0) && (age == 1);
      done    = (owner != 0) && (age >= 2) && (mv || age == TB_TIMEOUT + 1);
      e_iresp = done && owner == 1;
      e_dresp = done && owner == 2;

      chk("rnd_drdy", dmem_req_rdy, e_drdy);
      chk("rnd_irdy", imem_req_rdy, e_irdy);
      chk("rnd_enable", mem_enable, e_en);
      chk("rnd_iresp", imem_resp_val, e_iresp);
      chk("rnd_dresp", dmem_resp_val, e_dresp);
      chk("rnd_stall_if", stall_if, i_act && !e_iresp);
      chk("rnd_stall_mem", stall_mem, d_act && !e_dresp);
      chk("rnd_err", err_timeout, merr);
      if (e_en) begin
        chk("rnd_cmd", mem_cmd, t_cmd);
        chk("rnd_addr", mem_addr, t_addr);
        chk("rnd_wdata", mem_write_data, t_wdata);
        chk("rnd_mask", mem_mask, t_mask);
      end
      if (e_iresp) chk("rnd_idata", imem_resp_data, mv ? ld : 32'h0000_0013);
      if (e_dresp && (!mv || !t_cmd)) chk("rnd_ddata", dmem_resp_data, mv ? ld : 32'h0);

      if (done) begin
        if (!mv) merr = 1'b1;
        if (owner == 1) i_act = 1'b0; else d_act = 1'b0;
        owner = 0;
      end else if (owner != 0) begin
        age++;
      end
      if (e_drdy) begin
        owner = 2; age = 1;
        t_cmd = d_wr; t_addr = d_addr; t_wdata = d_wdata; t_mask = d_mask;
        starve = i_act ? ((starve < TB_STARVE) ? starve + 1 : starve) : 0;
      end else if (e_irdy) begin
        owner = 1; age = 1;
        t_cmd = 1'b0; t_addr = i_addr; t_wdata = '0; t_mask = '0;
        starve = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
